// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter.
//  - Register byte offsets from the block's base address.
//  - FSM state encodings (also visible on the arbiter's dbg_state port).
//  - INTNUM cause codes that are not tied to a device source.
package int_defs;

  localparam logic [3:0] OFF_IPEND  = 4'd0;
  localparam logic [3:0] OFF_IMASK  = 4'd2;
  localparam logic [3:0] OFF_ICAUSE = 4'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  localparam logic [3:0] INTNUM_NONE    = 4'hF;
  localparam logic [3:0] INTNUM_ILLEGAL = 4'h0;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Ports:
//  req   in  N  request vector
//  valid out 1  any request set
//  idx   out 4  index of the lowest set bit (0 when none)
module int_prio_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    valid = |req;
    idx   = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: captures device IRQ rising edges into sticky pending
// bits, masks them, and presents one registered request to the CPU core.
// Ports:
//  clk       system clock (posedge)
//  resetn    synchronous active-low reset
//  abus      bus address (word addressed, abus[0] ignored)
//  rbus      read data, driven only while re && register hit, else z
//  re, we    bus read / write enables
//  wbus      bus write data
//  irq       device interrupt lines, bit 0 highest priority
//  ie        core interrupt enable
//  intack    core acknowledges the presented request (one-cycle pulse)
//  reti      core retired RETI (one-cycle pulse)
//  intreq    registered request to the core
//  intnum    cause code: source i -> i+1, 4'hF when none
//  dbg_state current FSM state (ST_* encoding)
//
// Handshake: intreq/intnum are held stable while in REQ. A request is taken
// only by intack in a cycle where intreq=1; it may be withdrawn (intreq drops,
// intnum=F) if ie falls or the granted source stops being eligible. intack
// wins over withdrawal. After acceptance no new request is raised until reti.
module int_arbiter
  import int_defs::*;
#(
  parameter int               ABITS = 16,
  parameter int               DBITS = 16,
  parameter int               NSRC  = 3,
  parameter logic [ABITS-1:0] RBASE = 16'hFFD0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [ABITS-1:0] abus,
  inout  wire  [DBITS-1:0] rbus,
  input  logic             re,
  input  logic [DBITS-1:0] wbus,
  input  logic             we,
  input  logic [NSRC-1:0]  irq,
  input  logic             ie,
  input  logic             intack,
  input  logic             reti,
  output logic             intreq,
  output logic [3:0]       intnum,
  output logic [1:0]       dbg_state
);

  localparam logic [ABITS-1:0] A_IPEND  = RBASE + ABITS'(OFF_IPEND);
  localparam logic [ABITS-1:0] A_IMASK  = RBASE + ABITS'(OFF_IMASK);
  localparam logic [ABITS-1:0] A_ICAUSE = RBASE + ABITS'(OFF_ICAUSE);

  logic [NSRC-1:0] irq_q, pend, mask;
  logic [1:0]      state;
  logic [3:0]      gnt;
  logic            inservice;
  logic [3:0]      cause;

  logic            hit_pend, hit_mask, hit_cause;
  logic [NSRC-1:0] eligible, gnt_oh, pend_clr;
  logic            e_valid, e_gnt, ack;
  logic [3:0]      winner;
  logic [DBITS-1:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{abus[0], wbus[DBITS-1:NSRC]};

  // Word decode: the byte-select bit is ignored.
  assign hit_pend  = abus[ABITS-1:1] == A_IPEND[ABITS-1:1];
  assign hit_mask  = abus[ABITS-1:1] == A_IMASK[ABITS-1:1];
  assign hit_cause = abus[ABITS-1:1] == A_ICAUSE[ABITS-1:1];

  assign eligible = pend & mask;

  int_prio_enc #(.N(NSRC)) u_prio (
    .req   (eligible),
    .valid (e_valid),
    .idx   (winner)
  );

  assign gnt_oh = NSRC'(1) << gnt;
  assign e_gnt  = |(eligible & gnt_oh);
  assign ack    = (state == ST_REQ) && intack;

  // W1C from the bus and the acknowledged source; new edges are OR-ed in
  // after clearing so a same-cycle set survives.
  assign pend_clr = ((we && hit_pend) ? wbus[NSRC-1:0] : '0) | (ack ? gnt_oh : '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_q     <= '0;
      pend      <= '0;
      mask      <= '0;
      state     <= ST_IDLE;
      gnt       <= 4'd0;
      intreq    <= 1'b0;
      intnum    <= INTNUM_NONE;
      inservice <= 1'b0;
      cause     <= 4'd0;
    end else begin
      irq_q <= irq;
      pend  <= (pend & ~pend_clr) | (irq & ~irq_q);
      if (we && hit_mask) mask <= wbus[NSRC-1:0];

      case (state)
        ST_IDLE: begin
          if (ie && e_valid) begin
            state  <= ST_REQ;
            gnt    <= winner;
            intreq <= 1'b1;
            intnum <= winner + 4'd1;
          end
        end
        ST_REQ: begin
          if (intack) begin
            state     <= ST_SERV;
            intreq    <= 1'b0;
            inservice <= 1'b1;
            cause     <= intnum;
          end else if (!ie || !e_gnt) begin
            state  <= ST_IDLE;
            intreq <= 1'b0;
            intnum <= INTNUM_NONE;
          end
        end
        ST_SERV: begin
          if (reti) begin
            state     <= ST_IDLE;
            intnum    <= INTNUM_NONE;
            inservice <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          intreq <= 1'b0;
          intnum <= INTNUM_NONE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_pend) rdata[NSRC-1:0] = pend;
    if (hit_mask) rdata[NSRC-1:0] = mask;
    if (hit_cause) begin
      rdata[DBITS-1] = inservice;
      rdata[3:0]     = cause;
    end
  end

  assign rbus      = (re && (hit_pend || hit_mask || hit_cause)) ? rdata : 'z;
  assign dbg_state = state;

endmodule

// File: tb/tb_int_arbiter.sv
module tb_int_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] abus = '0;
  wire  [15:0] rbus;
  logic        re = 1'b0;
  logic [15:0] wbus = '0;
  logic        we = 1'b0;
  logic [2:0]  irq = '0;
  logic        ie = 1'b0;
  logic        intack = 1'b0;
  logic        reti = 1'b0;
  logic        intreq;
  logic [3:0]  intnum;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  int_arbiter dut (
    .clk(clk), .resetn(resetn), .abus(abus), .rbus(rbus), .re(re),
    .wbus(wbus), .we(we), .irq(irq), .ie(ie), .intack(intack), .reti(reti),
    .intreq(intreq), .intnum(intnum), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register index for an address: 0 IPEND, 1 IMASK, 2 ICAUSE, -1 miss.
  function automatic int reg_of(input logic [15:0] a);
    if (a >= 16'hFFD0 && a <= 16'hFFD5) return int'(a - 16'hFFD0) / 2;
    return -1;
  endfunction

  bit       m_ok = 0;
  bit [2:0] m_pend, m_mask, m_prev;
  int       m_phase;      // 0 waiting, 1 requesting, 2 being serviced
  int       m_src;
  bit       m_req;
  bit [3:0] m_num;
  bit       m_insv;
  bit [3:0] m_cause;

  function automatic logic [15:0] m_read(input int r);
    case (r)
      0: return {13'd0, m_pend};
      1: return {13'd0, m_mask};
      default: return {m_insv, 11'd0, m_cause};
    endcase
  endfunction

  // Compare process: advance model on each posedge, check 2 time units later.
  initial begin
    forever begin
      @(posedge clk);
      begin
        bit s_rst, s_ie, s_ack, s_reti, s_we, s_re;
        bit [2:0] s_irq;
        bit [15:0] s_wbus, s_abus;
        s_rst = !resetn; s_ie = ie; s_ack = intack; s_reti = reti;
        s_we = we; s_re = re; s_irq = irq; s_wbus = wbus; s_abus = abus;
        if (s_rst) begin
          m_ok = 1; m_pend = 0; m_mask = 0; m_prev = 0; m_phase = 0; m_src = 0;
          m_req = 0; m_num = 4'hF; m_insv = 0; m_cause = 0;
        end else if (m_ok) begin
          bit [2:0] elig, np;
          int first;
          elig = m_pend & m_mask;
          first = -1;
          for (int i = 0; i < 3; i++) if (elig[i] && first < 0) first = i;
          np = m_pend;
          if (s_we && reg_of(s_abus) == 0) np = np & ~s_wbus[2:0];
          if (m_phase == 1 && s_ack) np[m_src] = 0;
          np = np | (s_irq & ~m_prev);
          if (m_phase == 0) begin
            if (s_ie && first >= 0) begin
              m_phase = 1; m_src = first; m_req = 1; m_num = 4'(first + 1);
            end
          end else if (m_phase == 1) begin
            if (s_ack) begin
              m_phase = 2; m_req = 0; m_insv = 1; m_cause = m_num;
            end else if (!s_ie || !elig[m_src]) begin
              m_phase = 0; m_req = 0; m_num = 4'hF;
            end
          end else begin
            if (s_reti) begin
              m_phase = 0; m_num = 4'hF; m_insv = 0;
            end
          end
          if (s_we && reg_of(s_abus) == 1) m_mask = s_wbus[2:0];
          m_pend = np;
          m_prev = s_irq;
        end
        #2;
        if (m_ok) begin
          chk("model_intreq", {15'd0, intreq}, {15'd0, m_req});
          chk("model_intnum", {12'd0, intnum}, {12'd0, m_num});
          if (s_re && reg_of(s_abus) >= 0)
            chk("model_rbus", rbus, m_read(reg_of(s_abus)));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    we = 1; abus = a; wbus = d;
    step(1);
    we = 0; abus = '0; wbus = '0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    re = 1; abus = a;
    #1;
    chk(name, rbus, exp);
    re = 0; abus = '0;
  endtask

  task automatic pulse_ack();
    intack = 1; step(1); intack = 0;
  endtask

  task automatic pulse_reti();
    reti = 1; step(1); reti = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    resetn = 1;
    step(1);
    chk("rst_intreq", {15'd0, intreq}, 16'h0000);
    chk("rst_intnum", {12'd0, intnum}, 16'h000F);
    rd_chk("rst_imask", 16'hFFD2, 16'h0000);

    // 1: single source, full handshake
    bus_write(16'hFFD2, 16'h0007);
    ie = 1;
    irq = 3'b010; step(1); irq = 0; step(1);
    chk("t1_intreq", {15'd0, intreq}, 16'h0001);
    chk("t1_intnum", {12'd0, intnum}, 16'h0002);
    pulse_ack();
    chk("t1_intreq_ack", {15'd0, intreq}, 16'h0000);
    rd_chk("t1_ipend", 16'hFFD0, 16'h0000);
    rd_chk("t1_icause", 16'hFFD4, 16'h8002);
    pulse_reti();
    rd_chk("t1_icause_reti", 16'hFFD5, 16'h0002);

    // 2: simultaneous edges, priority then next grant after RETI
    irq = 3'b101; step(1); irq = 0; step(1);
    chk("t2_first", {12'd0, intnum}, 16'h0001);
    pulse_ack();
    pulse_reti();
    chk("t2_none", {12'd0, intnum}, 16'h000F);
    step(1);
    chk("t2_second", {12'd0, intnum}, 16'h0003);
    pulse_ack();
    pulse_reti();
    rd_chk("t2_ipend", 16'hFFD0, 16'h0000);

    // 3: IE low holds the request back
    ie = 0;
    irq = 3'b010; step(1); irq = 0; step(1);
    chk("t3_noreq", {15'd0, intreq}, 16'h0000);
    rd_chk("t3_ipend", 16'hFFD0, 16'h0002);
    ie = 1; step(1);
    chk("t3_req", {15'd0, intreq}, 16'h0001);
    chk("t3_num", {12'd0, intnum}, 16'h0002);

    // 4: masking withdraws the request
    bus_write(16'hFFD2, 16'h0000);
    step(1);
    chk("t4_withdraw", {15'd0, intreq}, 16'h0000);
    chk("t4_num", {12'd0, intnum}, 16'h000F);
    rd_chk("t4_ipend", 16'hFFD0, 16'h0002);
    bus_write(16'hFFD2, 16'h0007);
    step(1);
    chk("t4_return", {15'd0, intreq}, 16'h0001);
    chk("t4_return_num", {12'd0, intnum}, 16'h0002);
    pulse_ack();
    pulse_reti();

    // 5: re-edge during INTACK survives the clear
    irq = 3'b010; step(1); irq = 0; step(1);
    chk("t5_req", {15'd0, intreq}, 16'h0001);
    intack = 1; irq = 3'b010; step(1); intack = 0; irq = 0;
    rd_chk("t5_ipend", 16'hFFD0, 16'h0002);
    pulse_reti();
    step(1);
    chk("t5_again", {15'd0, intreq}, 16'h0001);
    chk("t5_again_num", {12'd0, intnum}, 16'h0002);
    pulse_ack();
    pulse_reti();

    // 6: reset while in service with pending work
    irq = 3'b001; step(1); irq = 0; step(1);
    pulse_ack();
    irq = 3'b101; step(1); irq = 0; step(1);
    rd_chk("t6_ipend", 16'hFFD0, 16'h0005);
    resetn = 0; step(1); resetn = 1;
    chk("t6_intreq", {15'd0, intreq}, 16'h0000);
    chk("t6_intnum", {12'd0, intnum}, 16'h000F);
    rd_chk("t6_ipend0", 16'hFFD0, 16'h0000);
    rd_chk("t6_imask0", 16'hFFD2, 16'h0000);
    rd_chk("t6_icause0", 16'hFFD4, 16'h0000);

    // Randomised traffic checked against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] addrs [8];
      addrs = '{16'hFFD0, 16'hFFD1, 16'hFFD2, 16'hFFD3, 16'hFFD4, 16'hFFD5, 16'hFFCE, 16'hFFD6};
      if ($urandom_range(0, 99) < 30) irq = 3'($urandom_range(0, 7));
      ie     = ($urandom_range(0, 99) < 85);
      intack = intreq ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
      reti   = ($urandom_range(0, 99) < 20);
      resetn = ($urandom_range(0, 999) >= 3);
      we     = ($urandom_range(0, 99) < 12);
      re     = !we && ($urandom_range(0, 99) < 40);
      abus   = addrs[$urandom_range(0, 7)];
      wbus   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 65535)) : 16'h0007;
      step(1);
    end
    we = 0; re = 0; intack = 0; reti = 0; irq = 0; resetn = 1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
